// File: rtl/mnacidpro_pkg.sv
// Shared definitions for the mnacidpro pneumatic sequencer: state encoding, valve
// bit positions, per-stage valve-open masks and the peristaltic pump pattern table.
package mnacidpro_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_BEAD    = 3'd1,
        ST_LYSIS   = 3'd2,
        ST_BIND    = 3'd3,
        ST_WASH    = 3'd4,
        ST_ELUTE   = 3'd5,
        ST_COLLECT = 3'd6,
        ST_SETTLE  = 3'd7
    } state_t;

    localparam int NUM_VALVES  = 11;
    localparam int V_LYSIS     = 0;
    localparam int V_WASH      = 1;
    localparam int V_ELUTE     = 2;
    localparam int V_DEAD_END  = 3;
    localparam int V_VERTICAL  = 4;
    localparam int V_HORIZ     = 5;
    localparam int V_WASTE     = 6;
    localparam int V_BEAD      = 7;
    localparam int V_LOOP_EXIT = 8;
    localparam int V_BEAD_TRAP = 9;
    localparam int V_COLLECT   = 10;

    // A set bit marks a valve that is vented (open) during the stage.
    localparam logic [NUM_VALVES-1:0] OPEN_BEAD    = 11'(1 << V_BEAD) | 11'(1 << V_VERTICAL);
    localparam logic [NUM_VALVES-1:0] OPEN_LYSIS   = 11'(1 << V_LYSIS) | 11'(1 << V_DEAD_END) |
                                                     11'(1 << V_HORIZ);
    localparam logic [NUM_VALVES-1:0] OPEN_BIND    = 11'(1 << V_VERTICAL) | 11'(1 << V_HORIZ);
    localparam logic [NUM_VALVES-1:0] OPEN_WASH    = 11'(1 << V_WASH) | 11'(1 << V_WASTE);
    localparam logic [NUM_VALVES-1:0] OPEN_ELUTE   = 11'(1 << V_ELUTE) | 11'(1 << V_HORIZ);
    localparam logic [NUM_VALVES-1:0] OPEN_COLLECT = 11'(1 << V_LOOP_EXIT) | 11'(1 << V_COLLECT);

    localparam logic [2:0] PUMP_HOLD = 3'b111;

    function automatic logic [2:0] pump_pattern(input logic [2:0] phase);
        logic [2:0] p;
        case (phase)
            3'd0:    p = 3'b101;
            3'd1:    p = 3'b100;
            3'd2:    p = 3'b110;
            3'd3:    p = 3'b010;
            3'd4:    p = 3'b011;
            3'd5:    p = 3'b001;
            default: p = PUMP_HOLD;
        endcase
        return p;
    endfunction

    // Control-line levels (1 = pressurised/closed) driven while in state s.
    function automatic logic [NUM_VALVES-1:0] valve_ctrl(input state_t s);
        logic [NUM_VALVES-1:0] v;
        case (s)
            ST_BEAD:    v = ~OPEN_BEAD;
            ST_LYSIS:   v = ~OPEN_LYSIS;
            ST_BIND:    v = ~OPEN_BIND;
            ST_WASH:    v = ~OPEN_WASH;
            ST_ELUTE:   v = ~OPEN_ELUTE;
            ST_COLLECT: v = ~OPEN_COLLECT;
            default:    v = '1;
        endcase
        return v;
    endfunction

    function automatic logic is_pumping(input state_t s);
        return (s != ST_IDLE) && (s != ST_SETTLE);
    endfunction

    function automatic state_t next_stage(input state_t s);
        state_t n;
        case (s)
            ST_BEAD:  n = ST_LYSIS;
            ST_LYSIS: n = ST_BIND;
            ST_BIND:  n = ST_WASH;
            ST_WASH:  n = ST_ELUTE;
            ST_ELUTE: n = ST_COLLECT;
            default:  n = ST_IDLE;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/mnacidpro_pump_phaser.sv
// Peristaltic pump phase generator: each of the six pattern phases is held for
// PUMP_DIV cycles; stroke marks the last cycle of phase 5.
module mnacidpro_pump_phaser
    import mnacidpro_pkg::*;
#(
    parameter int PUMP_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       restart,
    output logic [2:0] pump,
    output logic       stroke
);

    localparam int DW = (PUMP_DIV > 1) ? $clog2(PUMP_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(PUMP_DIV - 1);

    logic [DW-1:0] r_div;
    logic [2:0]    r_phase;
    logic          r_active;
    logic [2:0]    r_pump;
    logic [DW-1:0] w_div_n;
    logic [2:0]    w_phase_n;
    logic          w_phase_end;

    assign w_phase_end = (r_div == DIV_LAST);
    assign stroke      = r_active && w_phase_end && (r_phase == 3'd5);
    assign pump        = r_pump;

    // en/restart describe the coming cycle, so the pattern register lines up with the stage.
    always_comb begin
        w_div_n   = '0;
        w_phase_n = 3'd0;
        if (en && !restart) begin
            if (w_phase_end) begin
                w_phase_n = (r_phase == 3'd5) ? 3'd0 : r_phase + 3'd1;
            end else begin
                w_div_n   = r_div + 1'b1;
                w_phase_n = r_phase;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div    <= '0;
            r_phase  <= 3'd0;
            r_active <= 1'b0;
            r_pump   <= PUMP_HOLD;
        end else begin
            r_div    <= w_div_n;
            r_phase  <= w_phase_n;
            r_active <= en;
            r_pump   <= en ? pump_pattern(w_phase_n) : PUMP_HOLD;
        end
    end

endmodule

// File: rtl/mnacidpro_sequencer.sv
// Stage sequencer for the mnacidpro chip: bead load, lysis, bind, wash, elute and
// collect, with an all-closed settle between stages and a rotating collect outlet.
module mnacidpro_sequencer
    import mnacidpro_pkg::*;
#(
    parameter int SIZE            = 7,
    parameter int PUMP_DIV        = 4,
    parameter int BEAD_STROKES    = 2,
    parameter int LYSIS_STROKES   = 8,
    parameter int BIND_STROKES    = 16,
    parameter int WASH_STROKES    = 8,
    parameter int ELUTE_STROKES   = 8,
    parameter int COLLECT_STROKES = 4,
    parameter int SETTLE_CYC      = 8,
    localparam int OW = (SIZE > 1) ? $clog2(SIZE) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    output logic          busy,
    output logic          done,
    output logic [OW-1:0] outlet_idx,
    output logic [2:0]    stage,
    output logic          lysis_ctrl,
    output logic          wash_ctrl,
    output logic          elute_ctrl,
    output logic          dead_end_ctrl,
    output logic          vertical_ctrl,
    output logic          horiz_ctrl,
    output logic          waste_ctrl,
    output logic          bead_ctrl,
    output logic          loop_exit_ctrl,
    output logic          bead_trap_ctrl,
    output logic          collect_ctrl,
    output logic [2:0]    pump
);

    function automatic int max_i(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int MAX_STROKES = max_i(max_i(max_i(BEAD_STROKES, LYSIS_STROKES), max_i(BIND_STROKES, WASH_STROKES)),
                                       max_i(ELUTE_STROKES, COLLECT_STROKES));
    localparam int SW = $clog2(MAX_STROKES + 1);
    localparam int CW = $clog2(SETTLE_CYC + 1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYC - 1);
    localparam logic [OW-1:0] OUTLET_LAST = OW'(SIZE - 1);

    function automatic logic [SW-1:0] last_stroke(input state_t s);
        logic [SW-1:0] n;
        case (s)
            ST_BEAD:    n = SW'(BEAD_STROKES - 1);
            ST_LYSIS:   n = SW'(LYSIS_STROKES - 1);
            ST_BIND:    n = SW'(BIND_STROKES - 1);
            ST_WASH:    n = SW'(WASH_STROKES - 1);
            ST_ELUTE:   n = SW'(ELUTE_STROKES - 1);
            ST_COLLECT: n = SW'(COLLECT_STROKES - 1);
            default:    n = '0;
        endcase
        return n;
    endfunction

    state_t                r_state, w_next_state;
    state_t                r_ret, w_next_ret;
    logic                  r_aborting, w_next_aborting;
    logic [SW-1:0]         r_strokes, w_strokes_n;
    logic [CW-1:0]         r_settle, w_settle_n;
    logic                  w_done_n;
    logic                  w_outlet_inc;
    logic                  r_done;
    logic                  r_busy;
    logic [OW-1:0]         r_outlet;
    logic [NUM_VALVES-1:0] r_valves;
    logic                  w_stroke;
    logic                  w_phaser_en;
    logic                  w_phaser_restart;

    assign w_phaser_en      = is_pumping(w_next_state);
    assign w_phaser_restart = w_phaser_en && !is_pumping(r_state);

    mnacidpro_pump_phaser #(
        .PUMP_DIV (PUMP_DIV)
    ) u_phaser (
        .clk     (clk),
        .rst     (rst),
        .en      (w_phaser_en),
        .restart (w_phaser_restart),
        .pump    (pump),
        .stroke  (w_stroke)
    );

    // start is a level sampled only in IDLE; abort is a level honoured in every busy
    // state except the abort settle itself, and beats start when both are high in IDLE.
    always_comb begin
        w_next_state    = r_state;
        w_next_ret      = r_ret;
        w_next_aborting = r_aborting;
        w_strokes_n     = r_strokes;
        w_settle_n      = r_settle;
        w_done_n        = 1'b0;
        w_outlet_inc    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start && !abort) begin
                    w_next_state = ST_BEAD;
                    w_strokes_n  = '0;
                end
            end
            ST_SETTLE: begin
                if (r_settle == SETTLE_LAST) begin
                    w_settle_n = '0;
                    if (r_aborting || (r_ret == ST_IDLE)) begin
                        w_next_state    = ST_IDLE;
                        w_next_aborting = 1'b0;
                        w_done_n        = !r_aborting;
                        w_outlet_inc    = !r_aborting;
                    end else begin
                        w_next_state = r_ret;
                        w_strokes_n  = '0;
                    end
                end else begin
                    w_settle_n = r_settle + 1'b1;
                end
            end
            default: begin
                if (w_stroke) begin
                    if (r_strokes == last_stroke(r_state)) begin
                        w_next_state = ST_SETTLE;
                        w_next_ret   = next_stage(r_state);
                        w_settle_n   = '0;
                    end else begin
                        w_strokes_n = r_strokes + 1'b1;
                    end
                end
            end
        endcase

        if (abort && (r_state != ST_IDLE) && !r_aborting) begin
            w_next_state    = ST_SETTLE;
            w_next_ret      = ST_IDLE;
            w_next_aborting = 1'b1;
            w_settle_n      = '0;
            w_done_n        = 1'b0;
            w_outlet_inc    = 1'b0;
        end
    end

    // Output registers load from the next state so they change together with r_state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_ret      <= ST_IDLE;
            r_aborting <= 1'b0;
            r_strokes  <= '0;
            r_settle   <= '0;
            r_done     <= 1'b0;
            r_busy     <= 1'b0;
            r_outlet   <= '0;
            r_valves   <= '1;
        end else begin
            r_state    <= w_next_state;
            r_ret      <= w_next_ret;
            r_aborting <= w_next_aborting;
            r_strokes  <= w_strokes_n;
            r_settle   <= w_settle_n;
            r_done     <= w_done_n;
            r_busy     <= (w_next_state != ST_IDLE);
            r_valves   <= valve_ctrl(w_next_state);
            if (w_outlet_inc) begin
                r_outlet <= (r_outlet == OUTLET_LAST) ? '0 : r_outlet + 1'b1;
            end
        end
    end

    assign busy           = r_busy;
    assign done           = r_done;
    assign outlet_idx     = r_outlet;
    assign stage          = r_state;
    assign lysis_ctrl     = r_valves[V_LYSIS];
    assign wash_ctrl      = r_valves[V_WASH];
    assign elute_ctrl     = r_valves[V_ELUTE];
    assign dead_end_ctrl  = r_valves[V_DEAD_END];
    assign vertical_ctrl  = r_valves[V_VERTICAL];
    assign horiz_ctrl     = r_valves[V_HORIZ];
    assign waste_ctrl     = r_valves[V_WASTE];
    assign bead_ctrl      = r_valves[V_BEAD];
    assign loop_exit_ctrl = r_valves[V_LOOP_EXIT];
    assign bead_trap_ctrl = r_valves[V_BEAD_TRAP];
    assign collect_ctrl   = r_valves[V_COLLECT];

endmodule

// File: tb/tb_mnacidpro_sequencer.sv
// Scoreboard bench for mnacidpro_sequencer: every cycle the full output vector is
// compared with a trace queued when the stimulus that causes it is driven.
module tb_mnacidpro_sequencer;

    localparam int TB_SIZE     = 3;
    localparam int TB_PUMP_DIV = 2;
    localparam int TB_STROKES  = 1;
    localparam int TB_SETTLE   = 3;
    localparam int STAGE_CYC   = 6 * TB_PUMP_DIV * TB_STROKES;
    localparam int W           = 21;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SETTLE = 3'd7;

    // Bit positions inside the bench's packed valve vector.
    localparam int B_LYSIS = 10, B_WASH = 9, B_ELUTE = 8, B_DEAD = 7, B_VERT = 6, B_HORIZ = 5;
    localparam int B_WASTE = 4, B_BEAD = 3, B_LOOP = 2, B_TRAP = 1, B_COLLECT = 0;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       busy, done;
    logic [1:0] outlet_idx;
    logic [2:0] stage, pump;
    logic       lysis_ctrl, wash_ctrl, elute_ctrl, dead_end_ctrl, vertical_ctrl, horiz_ctrl;
    logic       waste_ctrl, bead_ctrl, loop_exit_ctrl, bead_trap_ctrl, collect_ctrl;

    logic [W-1:0] exp_q[$];
    int           n_checks = 0;
    int           n_fail   = 0;
    int           n_done   = 0;
    int           cyc      = 0;
    logic [1:0]   m_outlet = 2'd0;
    logic [1:0]   m_old    = 2'd0;

    mnacidpro_sequencer #(
        .SIZE            (TB_SIZE),
        .PUMP_DIV        (TB_PUMP_DIV),
        .BEAD_STROKES    (TB_STROKES),
        .LYSIS_STROKES   (TB_STROKES),
        .BIND_STROKES    (TB_STROKES),
        .WASH_STROKES    (TB_STROKES),
        .ELUTE_STROKES   (TB_STROKES),
        .COLLECT_STROKES (TB_STROKES),
        .SETTLE_CYC      (TB_SETTLE)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .abort          (abort),
        .busy           (busy),
        .done           (done),
        .outlet_idx     (outlet_idx),
        .stage          (stage),
        .lysis_ctrl     (lysis_ctrl),
        .wash_ctrl      (wash_ctrl),
        .elute_ctrl     (elute_ctrl),
        .dead_end_ctrl  (dead_end_ctrl),
        .vertical_ctrl  (vertical_ctrl),
        .horiz_ctrl     (horiz_ctrl),
        .waste_ctrl     (waste_ctrl),
        .bead_ctrl      (bead_ctrl),
        .loop_exit_ctrl (loop_exit_ctrl),
        .bead_trap_ctrl (bead_trap_ctrl),
        .collect_ctrl   (collect_ctrl),
        .pump           (pump)
    );

    // Clock and watchdog.
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d actual=timeout expected=finish", cyc);
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s cyc=%0d actual=%h expected=%h", tag, cyc, actual, expected);
        end
    endtask

    function automatic logic [W-1:0] mk(input logic b, input logic d, input logic [1:0] o,
                                        input logic [2:0] st, input logic [10:0] v, input logic [2:0] p);
        return {b, d, o, st, v, p};
    endfunction

    function automatic logic [10:0] vmask(input int s);
        logic [10:0] v;
        v = '1;
        case (s)
            1: begin v[B_BEAD] = 1'b0; v[B_VERT] = 1'b0; end
            2: begin v[B_LYSIS] = 1'b0; v[B_DEAD] = 1'b0; v[B_HORIZ] = 1'b0; end
            3: begin v[B_VERT] = 1'b0; v[B_HORIZ] = 1'b0; end
            4: begin v[B_WASH] = 1'b0; v[B_WASTE] = 1'b0; end
            5: begin v[B_ELUTE] = 1'b0; v[B_HORIZ] = 1'b0; end
            6: begin v[B_LOOP] = 1'b0; v[B_COLLECT] = 1'b0; end
            default: v = '1;
        endcase
        return v;
    endfunction

    function automatic logic [2:0] pat(input int ph);
        logic [2:0] p;
        case (ph)
            0: p = 3'b101;
            1: p = 3'b100;
            2: p = 3'b110;
            3: p = 3'b010;
            4: p = 3'b011;
            default: p = 3'b001;
        endcase
        return p;
    endfunction

    function automatic logic [W-1:0] idle_vec(input logic [1:0] o);
        return mk(1'b0, 1'b0, o, S_IDLE, 11'h7FF, 3'b111);
    endfunction

    // Driver side: one sample per cycle, #1 after the active edge.
    task automatic step();
        logic [W-1:0] obs;
        logic [W-1:0] e;
        @(posedge clk);
        #1;
        cyc++;
        obs = {busy, done, outlet_idx, stage,
               lysis_ctrl, wash_ctrl, elute_ctrl, dead_end_ctrl, vertical_ctrl, horiz_ctrl,
               waste_ctrl, bead_ctrl, loop_exit_ctrl, bead_trap_ctrl, collect_ctrl, pump};
        if (done === 1'b1) n_done++;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else e = idle_vec(m_outlet);
        check_eq("out_vec", 32'(obs), 32'(e));
    endtask

    task automatic push_run();
        m_old = m_outlet;
        for (int s = 1; s <= 6; s++) begin
            for (int t = 0; t < STAGE_CYC; t++)
                exp_q.push_back(mk(1'b1, 1'b0, m_old, 3'(s), vmask(s), pat((t / TB_PUMP_DIV) % 6)));
            for (int t = 0; t < TB_SETTLE; t++)
                exp_q.push_back(mk(1'b1, 1'b0, m_old, S_SETTLE, 11'h7FF, 3'b111));
        end
        m_outlet = (m_old == 2'd2) ? 2'd0 : m_old + 2'd1;
        exp_q.push_back(mk(1'b0, 1'b1, m_outlet, S_IDLE, 11'h7FF, 3'b111));
    endtask

    task automatic start_run();
        push_run();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic drain();
        int guard = 0;
        while (exp_q.size() > 0 && guard < 300) begin
            step();
            guard++;
        end
        check_eq("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_abort();
        exp_q.delete();
        for (int t = 0; t < TB_SETTLE; t++)
            exp_q.push_back(mk(1'b1, 1'b0, m_old, S_SETTLE, 11'h7FF, 3'b111));
        m_outlet = m_old;
        abort = 1'b1;
        step();
        abort = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (5) step();

        // Three back-to-back runs, with a start pulse during the second.
        start_run();
        drain();
        check_eq("outlet_run1", 32'(outlet_idx), 32'd1);
        start_run();
        repeat (20) step();
        start = 1'b1;
        step();
        start = 1'b0;
        drain();
        check_eq("outlet_run2", 32'(outlet_idx), 32'd2);
        start_run();
        drain();
        check_eq("outlet_run3", 32'(outlet_idx), 32'd0);
        check_eq("done_pulses", 32'(n_done), 32'd3);
        step();

        start_run();
        drain();
        check_eq("outlet_run4", 32'(outlet_idx), 32'd1);

        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        repeat (3) step();

        // Abort a few cycles into BIND, then try aborting again during the abort settle.
        start_run();
        repeat (34) step();
        do_abort();
        abort = 1'b1;
        step();
        abort = 1'b0;
        repeat (5) step();
        check_eq("outlet_abort", 32'(outlet_idx), 32'd1);
        check_eq("done_after_abort", 32'(n_done), 32'd4);

        // Synchronous reset in the middle of ELUTE.
        start_run();
        repeat (63) step();
        exp_q.delete();
        m_outlet = 2'd0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (4) step();
        check_eq("outlet_rst", 32'(outlet_idx), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
